// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one outstanding access, IDLE->REQ->WAIT->DONE handshake FSM.
// Optional YSYX_24100005_LSU_MISALIGN_EN: misaligned half/word ops complete with an error, no bus traffic.
module ysyx_24100005_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef struct packed {
    logic       ld;
    logic [2:0] f3;
    logic [1:0] off;
  } op_t;

  state_e      state_q;
  op_t         op_q;
  logic [7:0]  cnt_q;
  logic        rdy_q, req_q, we_q, ov_q, err_q;
  logic [31:0] addr_q, wdata_q, odata_q;
  logic [3:0]  wmask_q;

  logic        is_ld, is_st, acc, mis_d;
  logic [31:0] ea_d, wdata_d, ld_data_d;
  logic [3:0]  wmask_d;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign is_ld = (opcode == OP_LOAD);
  assign is_st = (opcode == OP_STORE);
  assign acc   = rdy_q & in_valid & (is_ld | is_st);
  assign ea_d  = base + offset;

  // funct3[1:0] selects size for both directions; 011/11x fall into the word case
`ifdef YSYX_24100005_LSU_MISALIGN_EN
  assign mis_d = ((funct3[1:0] == 2'b01) & ea_d[0]) | (funct3[1] & (ea_d[1:0] != 2'b00));
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = 32'h0;
    if (is_st) begin
      case (funct3[1:0])
        2'b00: begin
          wmask_d = 4'b0001 << ea_d[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        2'b01: begin
          wmask_d = 4'b0011 << {ea_d[1], 1'b0};
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          wmask_d = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

  assign lb = mem_rdata[{op_q.off, 3'b000} +: 8];
  assign lh = op_q.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data_d = 32'h0;
    if (op_q.ld) begin
      case (op_q.f3[1:0])
        2'b00:   ld_data_d = {{24{~op_q.f3[2] & lb[7]}}, lb};
        2'b01:   ld_data_d = {{16{~op_q.f3[2] & lh[15]}}, lh};
        default: ld_data_d = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= 8'h0;
      rdy_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      ov_q    <= 1'b0;
      odata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (acc) begin
            rdy_q   <= 1'b0;
            op_q    <= '{ld: is_ld, f3: funct3, off: ea_d[1:0]};
            if (mis_d) begin
              state_q <= S_DONE;
              ov_q    <= 1'b1;
              odata_q <= 32'h0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= is_st;
              addr_q  <= {ea_d[31:2], 2'b00};
              wdata_q <= wdata_d;
              wmask_q <= wmask_d;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            req_q <= 1'b0;
            cnt_q <= 8'h0;
            // grant and response together: skip WAIT
            if (mem_rvalid) begin
              state_q <= S_DONE;
              ov_q    <= 1'b1;
              odata_q <= ld_data_d;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid) begin
            state_q <= S_DONE;
            ov_q    <= 1'b1;
            odata_q <= ld_data_d;
            err_q   <= 1'b0;
          end else if (cnt_q + 8'd1 == TMO) begin
            state_q <= S_DONE;
            ov_q    <= 1'b1;
            odata_q <= 32'h0;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign out_valid = ov_q;
  assign out_data  = odata_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Scoreboard bench for ysyx_24100005_lsu: expected results queued at issue, popped on out handshake.
module tb_ysyx_24100005_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  opcode = 7'h0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] base = 32'h0, offset = 32'h0, store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_data;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_fail = 0;

  ysyx_24100005_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .base(base), .offset(offset),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_err", {31'b0, out_err}, {31'b0, e.err});
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) chk("rdy_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; opcode = op; funct3 = f3; base = b; offset = o; store_data = sd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic mem_txn(input int gnt_wait, input int rv_wait, input logic same,
                         input logic [31:0] rd);
    logic [31:0] a0;
    a0 = mem_addr;
    for (int i = 0; i < gnt_wait; i++) begin
      chk("req_hold", {31'b0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, a0);
      tick();
    end
    mem_gnt = 1'b1; mem_rvalid = same; mem_rdata = rd;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!same) begin
      chk("req_low_wait", {31'b0, mem_req}, 32'd0);
      for (int i = 0; i < rv_wait; i++) tick();
      mem_rvalid = 1'b1; mem_rdata = rd;
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic finish_op();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    if (!out_valid) chk("ov_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [2:0] f3; logic [1:0] off; logic [31:0] rd; logic [31:0] exp;
  } ld_vec_t;
  typedef struct {
    logic [2:0] f3; logic [31:0] b; logic [31:0] o; logic [31:0] sd;
    logic [31:0] addr; logic [3:0] mask; logic [31:0] wd;
  } st_vec_t;

  initial begin
    ld_vec_t lv[6];
    st_vec_t sv[5];
    lv[0] = '{3'b000, 2'd0, 32'h0000007F, 32'h0000007F};
    lv[1] = '{3'b100, 2'd1, 32'h0000F100, 32'h000000F1};
    lv[2] = '{3'b000, 2'd2, 32'h00AB0000, 32'hFFFFFFAB};
    lv[3] = '{3'b001, 2'd0, 32'h00008001, 32'hFFFF8001};
    lv[4] = '{3'b001, 2'd2, 32'h7FFE0000, 32'h00007FFE};
    lv[5] = '{3'b111, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D};
    sv[0] = '{3'b000, 32'h500, 32'h1, 32'h000000A5, 32'h500, 4'b0010, 32'hA5A5A5A5};
    sv[1] = '{3'b000, 32'h500, 32'h3, 32'h0000005A, 32'h500, 4'b1000, 32'h5A5A5A5A};
    sv[2] = '{3'b001, 32'h600, 32'h0, 32'hFFFF1357, 32'h600, 4'b0011, 32'h13571357};
    sv[3] = '{3'b011, 32'h700, 32'h0, 32'h01234567, 32'h700, 4'b1111, 32'h01234567};
    sv[4] = '{3'b010, 32'hFFFFFFF0, 32'h14, 32'h89ABCDEF, 32'h4, 4'b1111, 32'h89ABCDEF};

    // reset values
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // illegal opcode is ignored
    in_valid = 1'b1; opcode = 7'b0110011;
    tick(); tick();
    in_valid = 1'b0;
    chk("illegal_rdy", {31'b0, in_ready}, 32'd1);
    chk("illegal_req", {31'b0, mem_req}, 32'd0);

    // LB sign-extend from lane 3, grant immediately, rvalid one cycle later
    push(32'hFFFFFF80, 1'b0);
    issue(LD, 3'b000, 32'h80000000, 32'd3, 32'h0);
    chk("lb_req", {31'b0, mem_req}, 32'd1);
    chk("lb_we", {31'b0, mem_we}, 32'd0);
    chk("lb_addr", mem_addr, 32'h80000000);
    chk("lb_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("lb_wdata", mem_wdata, 32'h0);
    chk("lb_rdy_busy", {31'b0, in_ready}, 32'd0);
    mem_txn(0, 0, 1'b0, 32'h80FFFFFF);
    chk("lb_ov", {31'b0, out_valid}, 32'd1);
    finish_op();

    // SH to upper half
    push(32'h0, 1'b0);
    issue(ST, 3'b001, 32'h100, 32'd2, 32'h1234ABCD);
    chk("sh_we", {31'b0, mem_we}, 32'd1);
    chk("sh_addr", mem_addr, 32'h100);
    chk("sh_wmask", {28'b0, mem_wmask}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    mem_txn(2, 1, 1'b0, 32'hDEADBEEF);
    finish_op();

    // LHU with back-pressure; gnt+rvalid together gives 2-cycle latency
    out_ready = 1'b0;
    push(32'h0000BEEF, 1'b0);
    issue(LD, 3'b101, 32'h200, 32'd2, 32'h0);
    mem_txn(0, 0, 1'b1, 32'hBEEF0000);
    for (int i = 0; i < 3; i++) begin
      chk("lhu_hold_ov", {31'b0, out_valid}, 32'd1);
      chk("lhu_hold_data", out_data, 32'h0000BEEF);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("lhu_idle", {31'b0, in_ready}, 32'd1);
    chk("lhu_ov_low", {31'b0, out_valid}, 32'd0);

    // LW timeout after 4 cycles in WAIT
    push(32'h0, 1'b1);
    issue(LD, 3'b010, 32'h300, 32'd0, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("tmo_ov", {31'b0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    tick();

    // reset while in WAIT, late rvalid after release must be ignored
    issue(LD, 3'b010, 32'h400, 32'd0, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_req", {31'b0, mem_req}, 32'd0);
    chk("rstw_ov", {31'b0, out_valid}, 32'd0);
    chk("rstw_rdy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw_rdy_rel", {31'b0, in_ready}, 32'd1);
    chk("rstw_ov_rel", {31'b0, out_valid}, 32'd0);
    tick();
    chk("rstw_ov_late", {31'b0, out_valid}, 32'd0);
    chk("rstw_req_late", {31'b0, mem_req}, 32'd0);

    // misaligned LW
`ifdef YSYX_24100005_LSU_MISALIGN_EN
    push(32'h0, 1'b1);
    issue(LD, 3'b010, 32'h100, 32'd1, 32'h0);
    chk("mis_no_req", {31'b0, mem_req}, 32'd0);
    chk("mis_ov", {31'b0, out_valid}, 32'd1);
    tick();
`else
    push(32'h11223344, 1'b0);
    issue(LD, 3'b010, 32'h100, 32'd1, 32'h0);
    chk("mis_req", {31'b0, mem_req}, 32'd1);
    chk("mis_addr", mem_addr, 32'h100);
    mem_txn(0, 0, 1'b1, 32'h11223344);
    finish_op();
`endif

    foreach (lv[i]) begin
      push(lv[i].exp, 1'b0);
      issue(LD, lv[i].f3, 32'h800, {30'b0, lv[i].off}, 32'h0);
      chk("ld_wmask", {28'b0, mem_wmask}, 32'h0);
      mem_txn(i % 2, i % 3, i[0], lv[i].rd);
      finish_op();
    end

    foreach (sv[i]) begin
      push(32'h0, 1'b0);
      issue(ST, sv[i].f3, sv[i].b, sv[i].o, sv[i].sd);
      chk("st_we", {31'b0, mem_we}, 32'd1);
      chk("st_addr", mem_addr, sv[i].addr);
      chk("st_wmask", {28'b0, mem_wmask}, {28'b0, sv[i].mask});
      chk("st_wdata", mem_wdata, sv[i].wd);
      mem_txn(1, 0, 1'b0, 32'hFFFFFFFF);
      finish_op();
    end

    tick(); tick();
    chk("sb_left", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, max cycles from grant to mem_rvalid before error (8-bit counter).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  in  1  execute stage offers a memory op.
REQ-005 SHALL have port: in_ready  out  1  LSU accepts op (high only in IDLE).
REQ-006 SHALL have port: opcode  in  7  0000011 = load, 0100011 = store.
REQ-007 SHALL have port: funct3  in  3  width/sign selector.
REQ-008 SHALL have port: base  in  32  rs1 value.
REQ-009 SHALL have port: offset  in  32  sign-extended immediate.
REQ-010 SHALL have port: store_data  in  32  rs2 value.
REQ-011 SHALL have port: mem_req  out  1  memory request strobe.
REQ-012 SHALL have port: mem_we  out  1  1 = write.
REQ-013 SHALL have port: mem_addr  out  32  word-aligned address (bits [1:0] = 0).
REQ-014 SHALL have port: mem_wdata  out  32  lane-shifted store data.
REQ-015 SHALL have port: mem_wmask  out  4  byte enables.
REQ-016 SHALL have port: mem_gnt  in  1  memory accepts request.
REQ-017 SHALL have port: mem_rvalid  in  1  read data valid / write ack.
REQ-018 SHALL have port: mem_rdata  in  32  raw read word.
REQ-019 SHALL have port: out_valid  out  1  result ready for writeback.
REQ-020 SHALL have port: out_ready  in  1  writeback accepts result.
REQ-021 SHALL have port: out_data  out  32  extracted, extended load data (0 for stores).
REQ-022 SHALL have port: out_err  out  1  timeout or misalign error, qualified by out_valid.

Function
REQ-023 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
REQ-024 SHALL accept on in_valid & in_ready in IDLE; latch op, funct3, ea = base + offset (mod 2^32), store_data; go to REQ.
REQ-025 SHALL, in IDLE, ignore in_valid when opcode is neither load nor store (stays IDLE, in_ready held high).
REQ-026 SHALL hold mem_req high in REQ with stable addr/we/wdata/wmask until mem_gnt; on mem_gnt go to WAIT and clear counter.
REQ-027 SHALL, in WAIT, increment counter each cycle; on mem_rvalid capture mem_rdata, go DONE; if counter reaches TIMEOUT first, go DONE with out_err=1.
REQ-028 SHALL treat mem_gnt and mem_rvalid in the same cycle in REQ as grant then response: go directly to DONE, capturing data.
REQ-029 SHALL hold out_valid, out_data, out_err stable in DONE until out_ready; return to IDLE on out_ready; minimum accept-to-out_valid latency = 2 cycles.
REQ-030 SHALL extract loads by ea[1:0]: LB(000)/LBU(100) byte lane, LH(001)/LHU(101) halfword lane ea[1], LW(010) full word; sign-extend for LB/LH, zero-extend for LBU/LHU.
REQ-031 SHALL form stores: SB mask 0001<<ea[1:0], data byte replicated x4; SH mask 0011<<{ea[1],0}, data halfword replicated x2; SW mask 1111.
REQ-032 SHALL drive mem_wmask 0000 and mem_wdata 0 for loads; funct3 values 011/110/111 behave as LW/SW.
REQ-033 SHALL drive mem_req, out_valid low outside REQ and DONE respectively; in_ready low outside IDLE.

Reset
REQ-034 SHALL, when rst=0 at a clock edge, enter IDLE regardless of state, abandoning any in-flight access without further mem_req.
REQ-035 SHALL reset outputs: in_ready 0 during reset then 1, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wmask 0, out_valid 0, out_data 0, out_err 0, counter 0.

Configuration
REQ-036 SHALL honour macro YSYX_24100005_LSU_MISALIGN_EN.
REQ-037 SHALL, with macro defined, detect LH/LHU/SH with ea[0]=1 or LW/SW with ea[1:0]!=0, skip REQ/WAIT, go directly to DONE with out_err=1, out_data 0, no mem_req.
REQ-038 SHALL, without macro, perform misaligned ops by truncating to lane rules of REQ-030/031 with out_err only from timeout.

Verification
REQ-039 SHALL cover: LB base=0x80000000 off=3, rdata=0x80FFFFFF, gnt same cycle, rvalid +1 -> out_data=0xFFFFFF80, out_err=0.
REQ-040 SHALL cover: SH base=0x100 off=2, store_data=0x1234ABCD -> mem_we=1, mem_addr=0x100, mem_wmask=1100, mem_wdata=0xABCDABCD.
REQ-041 SHALL cover: LHU ea=0x202, rdata=0xBEEF0000, out_ready low 3 cycles -> out_data=0x0000BEEF held stable 3 cycles, then IDLE.
REQ-042 SHALL cover: LW granted, no rvalid for TIMEOUT=4 cycles -> out_valid with out_err=1 at counter==4.
REQ-043 SHALL cover: rst=0 asserted in WAIT -> next cycle mem_req=0, out_valid=0, in_ready=1 after release; late rvalid ignored.
REQ-044 SHALL cover: LW ea=0x101 with macro defined -> no mem_req, out_err=1; without macro -> mem_addr=0x100, out_err=0.
